// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state and requester-select types for mem_arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, SERVE_DATA, SERVE_INSTR} state_e;
    typedef enum logic {SEL_DATA, SEL_INSTR} sel_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (data, instruction) arbiter onto a single shared memory port
// Ports: clk, reset_n (async active-low)
//        instr_m_*  instruction read requester (access/address in, ack/data_in out)
//        data_m_*   data requester (access/address/wr_en/data_out/bytesel in, ack/data_in out)
//        q_m_*      shared memory request out, q_m_ack/q_m_data_in back
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_m_access,
    input  logic [19:1] instr_m_address,
    output logic        instr_m_ack,
    output logic [15:0] instr_m_data_in,
    input  logic        data_m_access,
    input  logic [19:1] data_m_address,
    input  logic        data_m_wr_en,
    input  logic [15:0] data_m_data_out,
    input  logic [1:0]  data_m_bytesel,
    output logic        data_m_ack,
    output logic [15:0] data_m_data_in,
    output logic        q_m_access,
    output logic [19:1] q_m_address,
    output logic        q_m_wr_en,
    output logic [15:0] q_m_data_out,
    output logic [1:0]  q_m_bytesel,
    input  logic        q_m_ack,
    input  logic [15:0] q_m_data_in
);
    state_e      state_q, state_d;
    sel_e        last_q;
    logic [19:1] addr_q;
    logic        wr_q;
    logic [15:0] dout_q;
    logic [1:0]  bsel_q;
    logic        pick_data;
    // On a tie, data wins unless round-robin says instruction is owed a turn.
    assign pick_data = data_m_access && (!instr_m_access || !ROUND_ROBIN || last_q == SEL_INSTR);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = pick_data ? SERVE_DATA : instr_m_access ? SERVE_INSTR : IDLE;
            SERVE_DATA,
            SERVE_INSTR: state_d = q_m_ack ? IDLE : state_q;
            default:     state_d = IDLE;
        endcase
    end
    always_comb begin
        q_m_access      = state_q != IDLE;
        data_m_ack      = state_q == SERVE_DATA && q_m_ack;
        instr_m_ack     = state_q == SERVE_INSTR && q_m_ack;
        data_m_data_in  = data_m_ack ? q_m_data_in : 16'h0;
        instr_m_data_in = instr_m_ack ? q_m_data_in : 16'h0;
        q_m_address     = addr_q;
        q_m_wr_en       = wr_q;
        q_m_data_out    = dout_q;
        q_m_bytesel     = bsel_q;
    end
    // Request fields are captured at grant so the requester may change them mid-transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= SEL_INSTR;
            addr_q <= '0;
            wr_q   <= 1'b0;
            dout_q <= '0;
            bsel_q <= '0;
        end else if (state_q == IDLE && state_d == SERVE_DATA) begin
            addr_q <= data_m_address;
            wr_q   <= data_m_wr_en;
            dout_q <= data_m_data_out;
            bsel_q <= data_m_bytesel;
        end else if (state_q == IDLE && state_d == SERVE_INSTR) begin
            addr_q <= instr_m_address;
            wr_q   <= 1'b0;
            dout_q <= '0;
            bsel_q <= 2'b11;
        end else if (data_m_ack) begin
            last_q <= SEL_DATA;
        end else if (instr_m_ack) begin
            last_q <= SEL_INSTR;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks a round-robin and a data-priority arbiter against a transaction-level model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        instr_m_access = 1'b0, data_m_access = 1'b0, data_m_wr_en = 1'b0, q_m_ack = 1'b0;
    logic [18:0] instr_m_address = '0, data_m_address = '0;
    logic [15:0] data_m_data_out = '0, q_m_data_in = '0;
    logic [1:0]  data_m_bytesel = '0;
    logic        q_acc [2], q_wr [2], i_ack [2], d_ack [2];
    logic [18:0] q_addr [2];
    logic [15:0] q_dout [2], i_din [2], d_din [2];
    logic [1:0]  q_bsel [2];
    // model: own 0=idle 1=data 2=instr; last 1=data 2=instr
    int          m_own [2], m_last [2];
    logic [18:0] m_addr [2];
    logic        m_wr [2];
    logic [15:0] m_dout [2];
    logic [1:0]  m_bsel [2];
    int n_checks = 0, n_fail = 0;
    int drv = 0, d_left = 0, i_left = 0, n_dack = 0, n_iack = 0, i_ack_cyc = -1;
    logic ev_d, ev_i;
    logic [15:0] i_seen;
    int ord [$];

    always #5 clk = ~clk;

    mem_arbiter #(.ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_m_access(instr_m_access), .instr_m_address(instr_m_address),
        .instr_m_ack(i_ack[0]), .instr_m_data_in(i_din[0]),
        .data_m_access(data_m_access), .data_m_address(data_m_address), .data_m_wr_en(data_m_wr_en),
        .data_m_data_out(data_m_data_out), .data_m_bytesel(data_m_bytesel),
        .data_m_ack(d_ack[0]), .data_m_data_in(d_din[0]),
        .q_m_access(q_acc[0]), .q_m_address(q_addr[0]), .q_m_wr_en(q_wr[0]),
        .q_m_data_out(q_dout[0]), .q_m_bytesel(q_bsel[0]),
        .q_m_ack(q_m_ack), .q_m_data_in(q_m_data_in)
    );

    mem_arbiter #(.ROUND_ROBIN(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .instr_m_access(instr_m_access), .instr_m_address(instr_m_address),
        .instr_m_ack(i_ack[1]), .instr_m_data_in(i_din[1]),
        .data_m_access(data_m_access), .data_m_address(data_m_address), .data_m_wr_en(data_m_wr_en),
        .data_m_data_out(data_m_data_out), .data_m_bytesel(data_m_bytesel),
        .data_m_ack(d_ack[1]), .data_m_data_in(d_din[1]),
        .q_m_access(q_acc[1]), .q_m_address(q_addr[1]), .q_m_wr_en(q_wr[1]),
        .q_m_data_out(q_dout[1]), .q_m_bytesel(q_bsel[1]),
        .q_m_ack(q_m_ack), .q_m_data_in(q_m_data_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int w;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_q_access", k), q_acc[k], m_own[k] != 0);
            if (m_own[k] != 0) begin
                chk($sformatf("d%0d_q_addr", k), q_addr[k], m_addr[k]);
                chk($sformatf("d%0d_q_wr", k), q_wr[k], m_wr[k]);
                chk($sformatf("d%0d_q_dout", k), q_dout[k], m_dout[k]);
                chk($sformatf("d%0d_q_bsel", k), q_bsel[k], m_bsel[k]);
            end
            chk($sformatf("d%0d_i_ack", k), i_ack[k], m_own[k] == 2 && q_m_ack);
            chk($sformatf("d%0d_i_din", k), i_din[k], (m_own[k] == 2 && q_m_ack) ? q_m_data_in : 16'h0);
            chk($sformatf("d%0d_d_ack", k), d_ack[k], m_own[k] == 1 && q_m_ack);
            chk($sformatf("d%0d_d_din", k), d_din[k], (m_own[k] == 1 && q_m_ack) ? q_m_data_in : 16'h0);
        end
        ev_d = d_ack[drv];
        ev_i = i_ack[drv];
        if (ev_i) i_seen = i_din[drv];
        for (int k = 0; k < 2; k++) begin
            if (m_own[k] == 0) begin
                w = 0;
                if (data_m_access && instr_m_access) w = (k == 0 && m_last[k] == 1) ? 2 : 1;
                else if (data_m_access) w = 1;
                else if (instr_m_access) w = 2;
                if (w == 1) begin
                    m_addr[k] = data_m_address; m_wr[k] = data_m_wr_en;
                    m_dout[k] = data_m_data_out; m_bsel[k] = data_m_bytesel;
                end else if (w == 2) begin
                    m_addr[k] = instr_m_address; m_wr[k] = 1'b0;
                    m_dout[k] = 16'h0; m_bsel[k] = 2'b11;
                end
                m_own[k] = w;
            end else if (q_m_ack) begin
                m_last[k] = m_own[k];
                m_own[k] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        q_m_ack = 1'b1;
        q_m_data_in = 16'hffff;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_q_access", k), q_acc[k], 0);
            chk($sformatf("rst%0d_q_addr", k), q_addr[k], 0);
            chk($sformatf("rst%0d_q_wr", k), q_wr[k], 0);
            chk($sformatf("rst%0d_q_dout", k), q_dout[k], 0);
            chk($sformatf("rst%0d_q_bsel", k), q_bsel[k], 0);
            chk($sformatf("rst%0d_acks", k), {i_ack[k], d_ack[k]}, 0);
            chk($sformatf("rst%0d_dins", k), {i_din[k], d_din[k]}, 0);
            m_own[k] = 0; m_last[k] = 2; m_addr[k] = '0; m_wr[k] = 1'b0; m_dout[k] = '0; m_bsel[k] = '0;
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        q_m_ack = 1'b0;
    endtask

    task automatic run(input int ncyc, input int lat, input logic [15:0] dv, input bit chg);
        int cnt;
        cnt = 0;
        n_dack = 0; n_iack = 0; i_ack_cyc = -1;
        ord.delete();
        for (int c = 0; c < ncyc; c++) begin
            cnt = q_acc[drv] ? cnt + 1 : 0;
            q_m_ack = q_acc[drv] && cnt >= lat;
            q_m_data_in = dv;
            data_m_access = d_left > 0;
            instr_m_access = i_left > 0;
            if (chg && c > 0) begin
                data_m_address = 19'($urandom);
                data_m_data_out = 16'($urandom);
                data_m_bytesel = 2'($urandom);
                data_m_wr_en = 1'($urandom);
            end
            cycle();
            if (ev_d) begin d_left--; n_dack++; ord.push_back(1); end
            if (ev_i) begin i_left--; n_iack++; i_ack_cyc = c; ord.push_back(2); end
        end
        data_m_access = 1'b0;
        instr_m_access = 1'b0;
        q_m_ack = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();
        // instruction-only read, memory answers on the fourth access cycle
        instr_m_address = 19'h7fff0; drv = 0; i_left = 1; d_left = 0;
        run(8, 4, 16'hbeef, 1'b0);
        chk("r034_iack_cnt", n_iack, 1);
        chk("r034_iack_cycle", i_ack_cyc, 4);
        chk("r034_idata", i_seen, 16'hbeef);
        chk("r034_dack_cnt", n_dack, 0);
        // data write with inputs scrambled after grant
        data_m_address = 19'h00123; data_m_data_out = 16'h55aa; data_m_bytesel = 2'b10; data_m_wr_en = 1'b1;
        d_left = 1; i_left = 0;
        run(8, 3, 16'h1234, 1'b1);
        chk("r037_dack_cnt", n_dack, 1);
        // round-robin ties straight after reset
        do_reset();
        instr_m_address = 19'h00400; data_m_address = 19'h00200; data_m_wr_en = 1'b0;
        drv = 0; d_left = 2; i_left = 2;
        run(30, 2, 16'h0a0a, 1'b0);
        chk("r035_n", ord.size(), 4);
        chk("r035_o0", ord[0], 1);
        chk("r035_o1", ord[1], 2);
        chk("r035_o2", ord[2], 1);
        chk("r035_o3", ord[3], 2);
        // data-priority arbiter with data requesting three times
        do_reset();
        drv = 1; d_left = 3; i_left = 1;
        run(30, 2, 16'h0b0b, 1'b0);
        chk("r036_n", ord.size(), 4);
        chk("r036_o0", ord[0], 1);
        chk("r036_o1", ord[1], 1);
        chk("r036_o2", ord[2], 1);
        chk("r036_o3", ord[3], 2);
        // reset in the middle of an instruction transaction
        drv = 0; i_left = 1; d_left = 0;
        run(3, 99, 16'h0c0c, 1'b0);
        chk("r038_busy", q_acc[0], 1);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            q_m_ack = 1'b1;
            q_m_data_in = 16'($urandom);
            cycle();
        end
        q_m_ack = 1'b0;
        d_left = 1; i_left = 1;
        run(20, 2, 16'h0d0d, 1'b0);
        chk("r038_first", ord[0], 1);
        // random traffic, including acks while idle and requesters dropping early
        for (int c = 0; c < 400; c++) begin
            data_m_access = ($urandom % 4) != 0;
            instr_m_access = ($urandom % 4) != 0;
            data_m_address = 19'($urandom);
            instr_m_address = 19'($urandom);
            data_m_data_out = 16'($urandom);
            data_m_bytesel = 2'($urandom);
            data_m_wr_en = 1'($urandom);
            q_m_ack = ($urandom % 3) == 0;
            q_m_data_in = 16'($urandom);
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = alternate grant on simultaneous requests; 0 = data port always wins ties.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 instr_m_access  input  1  instruction (prefetch) read request; held until instr_m_ack.
REQ-005 instr_m_address  input  19  instruction word address [19:1].
REQ-006 instr_m_ack  output  1  instruction transfer complete, one cycle.
REQ-007 instr_m_data_in  output  16  instruction read data, valid with instr_m_ack.
REQ-008 data_m_access  input  1  EU data request; held until data_m_ack.
REQ-009 data_m_address  input  19  data word address [19:1].
REQ-010 data_m_wr_en  input  1  1 = write, 0 = read.
REQ-011 data_m_data_out  input  16  write data.
REQ-012 data_m_bytesel  input  2  byte enables {high, low}.
REQ-013 data_m_ack  output  1  data transfer complete, one cycle.
REQ-014 data_m_data_in  output  16  data read data, valid with data_m_ack.
REQ-015 q_m_access, q_m_address[19], q_m_wr_en, q_m_data_out[16], q_m_bytesel[2]  output  shared memory request.
REQ-016 q_m_ack  input  1; q_m_data_in  input  16  shared memory completion and read data.

Function
REQ-017 FSM states IDLE, SERVE_DATA, SERVE_INSTR; the SERVE states are left only on q_m_ack.
REQ-018 IDLE, only data_m_access -> SERVE_DATA next cycle; only instr_m_access -> SERVE_INSTR next cycle; neither -> stay IDLE.
REQ-019 IDLE, both requests, ROUND_ROBIN=1: grant the port not served last; ROUND_ROBIN=0: grant data.
REQ-020 On grant, latch address, wr_en, data_out and bytesel of the winner; instruction grant latches wr_en=0, bytesel=2'b11, data_out=0.
REQ-021 q_m_access=1 exactly while state is SERVE_*; q_m_* fields driven from latched values, stable for whole transaction.
REQ-022 Latency: request at cycle N in IDLE -> q_m_access at N+1 minimum.
REQ-023 q_m_ack at cycle M in SERVE_X -> X_m_ack=1 at M (combinational), X_m_data_in=q_m_data_in at M, state=IDLE at M+1, q_m_access=0 at M+1.
REQ-024 Ungranted port's ack=0 and data_in=16'h0 always; q_m_ack in IDLE is ignored.
REQ-025 Back-to-back: minimum one IDLE cycle between transactions; pending other port granted at M+1 decision, q_m_access at M+2.
REQ-026 last_served register updated on each ack to the acked port; reset value = instruction, so data wins first tie.
REQ-027 A requester dropping access mid-transaction does not abort; transaction completes and ack is still delivered.
REQ-028 Requester changing address/data mid-transaction has no effect on q_m_* (latched).
REQ-029 No combinational path from any *_m_access to q_m_*.

Reset
REQ-030 reset_n low at any time, including mid-transaction: state=IDLE, last_served=instruction, latched fields=0, all outputs 0 immediately (asynchronous).
REQ-031 First grant possible on the first rising edge after reset_n deasserts.

Structure
REQ-032 Shared package holds the FSM state enum and the requester-select enum (DATA, INSTR).
REQ-033 Single module; no sub-module.

Verification
REQ-034 Instr read only, addr 19'h7fff0, memory acks after 3 cycles with 16'hbeef -> q_m_access cycles 1-4, instr_m_ack at cycle 4, data 16'hbeef, data_m_ack never.
REQ-035 Both request same cycle after reset, ROUND_ROBIN=1 -> data served first, then instr; second q_m_access starts 2 cycles after first ack; third tie -> data.
REQ-036 ROUND_ROBIN=0, both requesting continuously for 3 transactions -> three data grants, instr only after data_m_access drops.
REQ-037 Data write addr 19'h00123, data 16'h55aa, bytesel 2'b10; requester changes inputs mid-transaction -> q_m_* hold 19'h00123/16'h55aa/2'b10/wr_en=1 until ack.
REQ-038 reset_n pulled low during SERVE_INSTR before ack -> all outputs 0 immediately; after release, no ack to either port until a new request; next tie granted to data.
